mux_tree_pipe: RTL and testbench
================================

Name: mux_tree_pipe

Overview:
- Parametrised, pipelined N:1 multiplexer with N = 2**SEL_W channels, each DATA_W bits wide.
- Built as a binary tree of 2:1 selection levels, with one register stage per level.
- Level k is steered by sel bit k, LSB first: level 0 pairs channels (2i, 2i+1).
- Valid/ready handshakes on both sides; throughput is one selection per cycle; used as the wide-datapath successor to the 8:1 combinational tree.

Parameters:
DATA_W, 8, width of each channel and of out_data (>=1)
SEL_W, 3, select width; channel count N = 2**SEL_W; tree depth and latency = SEL_W (>=1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_data  input  N*DATA_W  flat channel bus; channel i = in_data[i*DATA_W +: DATA_W]
sel  input  SEL_W  channel index, sampled with in_data on accept
in_valid  input  1  upstream presents in_data/sel
in_ready  output  1  block accepts this cycle
out_data  output  DATA_W  selected channel value
out_sel  output  SEL_W  echo of the sel that produced out_data
out_valid  output  1  out_data/out_sel valid
out_ready  input  1  downstream accepts

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Transfers:
  - Input transfer happens on a rising edge with in_valid && in_ready.
  - Output transfer happens on a rising edge with out_valid && out_ready.
- Stage k (k = 0..SEL_W-1):
  - Holds valid bit v[k], 2**(SEL_W-1-k) partial words, and the full sel of its item.
  - Stage 0 loads pair results muxed by sel[0] from in_data.
  - Stage k>0 loads from stage k-1 pairs muxed by the carried sel[k].
  - Last stage drives out_data, out_sel, out_valid = v[SEL_W-1].
- Flow control is a per-stage elastic pipeline:
  - ready[SEL_W-1] = out_ready.
  - ready[k] = !v[k+1] || ready[k+1] for k < SEL_W-1.
  - Stage k advances iff !v[k] || ready[k].
  - in_ready = !v[0] || ready[0], combinational.
- When stage k advances:
  - v[k] <= the valid of its source (in_valid for k=0, v[k-1] otherwise).
  - Its data and sel load from that source.
- When stage k does not advance, it holds data, sel and v unchanged.
- Out_data and out_sel must stay stable while out_valid && !out_ready.
- Latency with no backpressure: an item accepted at edge T is presented with out_valid=1 after edge T+SEL_W-1, i.e. it transfers at edge T+SEL_W at the earliest. For SEL_W=3 it is visible 2 cycles after acceptance.
- Capacity: SEL_W items in flight, no loss or duplication; output order equals acceptance order.
- Bubble collapsing: an empty stage accepts even while a downstream stage is stalled.
- Result: out_data = in_data[sel*DATA_W +: DATA_W] as sampled at acceptance. Later changes to in_data or sel do not affect in-flight items.
- Reset:
  - While rst=1 at an edge, all v[k] <= 0 and all data and sel registers <= 0.
  - After that edge: out_valid=0, out_data=0, out_sel=0.
  - in_ready=1 once all v are clear, independent of out_ready.
  - Reset mid-operation discards all in-flight items; none emerge afterwards.
  - An input offered in the reset cycle is not accepted.
- Boundary cases:
  - SEL_W=1: single stage (plain registered 2:1).
  - Full pipeline with out_ready=0 forces in_ready=0.
  - Full pipeline with out_ready=1 sustains accept and emit in the same cycle.

Test Plan:
1. Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, out_data=8'h00, out_sel=0, in_ready=1; no item emerges later.
2. Streaming (defaults): channel i = 8'h10+i; sel 0..7 on consecutive cycles, in_valid=1, out_ready=1 -> out_data 8'h10..8'h17 on 8 consecutive cycles, first one 2 cycles after first accept; out_sel 0..7.
3. Backpressure: out_ready=0, offer 5 items sel=7,6,5,4,3 -> exactly 3 accepted, then in_ready=0; out_data holds 8'h17 stable. Release out_ready -> out_data 8'h17,8'h16,8'h15,8'h14,8'h13 in order, no gaps after the first.
4. Bubbles: in_valid toggling 1,0,1,0 with sel=2,x,5 -> out_valid toggles 1,0,1 with out_data 8'h12, 8'h15; out_ready toggling does not reorder.
5. Mid-operation reset: 3 items in flight (sel=1,2,3), pulse rst 1 cycle -> out_valid=0 next cycle and stays 0 until a new item is accepted.
6. SEL_W=1, DATA_W=16: in_data={16'hBEEF,16'hCAFE}, sel=1 then 0 -> 16'hBEEF then 16'hCAFE, each visible the cycle after its accept edge.

Source files
------------

// File: rtl/mux_tree_pipe.sv
// Pipelined 2**SEL_W:1 multiplexer tree with one register stage per select bit
// and an elastic valid/ready pipeline that collapses bubbles.
module mux_tree_pipe #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [(2**SEL_W)*DATA_W-1:0]  in_data,
    input  logic [SEL_W-1:0]              sel,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic [SEL_W-1:0]              out_sel,
    output logic                          out_valid,
    input  logic                          out_ready
);

    logic [SEL_W-1:0] v_s;
    logic [SEL_W-1:0] ready_s;
    logic [SEL_W-1:0] adv_s;
    logic             acc_s;

    // Stage k may pass data on when out_ready is high or any later stage is empty.
    always_comb begin
        ready_s = '0;
        acc_s   = out_ready;
        for (int k = SEL_W - 1; k >= 0; k--) begin
            ready_s[k] = acc_s;
            acc_s      = acc_s | ~v_s[k];
        end
    end

    assign adv_s    = ~v_s | ready_s;
    assign in_ready = adv_s[0];

    for (genvar k = 0; k < SEL_W; k++) begin : stage_g
        localparam int W = 2**(SEL_W - 1 - k);

        logic [2*W*DATA_W-1:0] src_data_s;
        logic [SEL_W-1:0]      src_sel_s;
        logic                  src_v_s;
        logic [W*DATA_W-1:0]   nxt_s;
        logic [W*DATA_W-1:0]   data_r;
        logic [SEL_W-1:0]      sel_r;
        logic                  v_r;

        if (k == 0) begin : src_g
            assign src_data_s = in_data;
            assign src_sel_s  = sel;
            assign src_v_s    = in_valid;
        end else begin : src_g
            assign src_data_s = stage_g[k-1].data_r;
            assign src_sel_s  = stage_g[k-1].sel_r;
            assign src_v_s    = stage_g[k-1].v_r;
        end

        // Pairwise 2:1 reduction steered by this level's select bit.
        always_comb begin
            nxt_s = '0;
            for (int i = 0; i < W; i++) begin
                if (src_sel_s[k]) begin
                    nxt_s[i*DATA_W +: DATA_W] = src_data_s[(2*i+1)*DATA_W +: DATA_W];
                end else begin
                    nxt_s[i*DATA_W +: DATA_W] = src_data_s[(2*i)*DATA_W +: DATA_W];
                end
            end
        end

        // Stage register: loads when the stage advances, otherwise holds.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_r    <= 1'b0;
                data_r <= '0;
                sel_r  <= '0;
            end else if (adv_s[k]) begin
                v_r    <= src_v_s;
                data_r <= nxt_s;
                sel_r  <= src_sel_s;
            end
        end

        assign v_s[k] = v_r;
    end

    assign out_data  = stage_g[SEL_W-1].data_r;
    assign out_sel   = stage_g[SEL_W-1].sel_r;
    assign out_valid = stage_g[SEL_W-1].v_r;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench for mux_tree_pipe: default 8:1 instance plus a SEL_W=1 instance.
module tb_mux_tree_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic [2:0]  sel;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  out_data;
    logic [2:0]  out_sel;
    logic [7:0]  exp0;

    logic [31:0] in_data1;
    logic [0:0]  sel1, out_sel1;
    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [15:0] out_data1;
    logic [15:0] exp1;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    logic [10:0] q0[$];
    logic [16:0] q1[$];
    logic        stall_prev = 1'b0;
    logic [7:0]  prev_data;

    always #5 clk = ~clk;

    mux_tree_pipe #(.DATA_W(8), .SEL_W(3)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready));

    mux_tree_pipe #(.DATA_W(16), .SEL_W(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data1), .sel(sel1), .in_valid(in_valid1),
        .in_ready(in_ready1), .out_data(out_data1), .out_sel(out_sel1),
        .out_valid(out_valid1), .out_ready(out_ready1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer0(input logic [2:0] s, input logic [7:0] e);
        in_valid = 1'b1;
        sel      = s;
        exp0     = e;
    endtask

    task automatic drain0();
        for (int i = 0; i < 40 && q0.size() != 0; i++) step();
        chk("drain0", q0.size(), 32'd0);
    endtask

    // Scoreboard for the 8:1 instance: push on accept, pop and compare on emit.
    always @(negedge clk) begin
        logic [10:0] e;
        if (rst) begin
            q0.delete();
            stall_prev = 1'b0;
        end else begin
            if (in_valid && in_ready) q0.push_back({sel, exp0});
            if (stall_prev) chk("stable_data", {24'd0, out_data}, {24'd0, prev_data});
            if (out_valid && out_ready) begin
                if (q0.size() == 0) begin
                    chk("unexpected_out0", 32'd1, 32'd0);
                end else begin
                    e = q0.pop_front();
                    chk("out_data0", {24'd0, out_data}, {24'd0, e[7:0]});
                    chk("out_sel0", {29'd0, out_sel}, {29'd0, e[10:8]});
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // Scoreboard for the SEL_W=1 instance.
    always @(negedge clk) begin
        logic [16:0] e;
        if (rst) begin
            q1.delete();
        end else begin
            if (in_valid1 && in_ready1) q1.push_back({sel1, exp1});
            if (out_valid1 && out_ready1) begin
                if (q1.size() == 0) begin
                    chk("unexpected_out1", 32'd1, 32'd0);
                end else begin
                    e = q1.pop_front();
                    chk("out_data1", {16'd0, out_data1}, {16'd0, e[15:0]});
                    chk("out_sel1", {31'd0, out_sel1}, {31'd0, e[16]});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [2:0] bp_sel [5];
        logic [7:0] bp_exp [5];
        logic [2:0] tg_sel [3];
        logic [7:0] tg_exp [3];
        logic       acc;
        int         idx;

        bp_sel = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3};
        bp_exp = '{8'h17, 8'h16, 8'h15, 8'h14, 8'h13};
        tg_sel = '{3'd1, 3'd6, 3'd0};
        tg_exp = '{8'h11, 8'h16, 8'h10};

        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'h10 + 8'(i);
        in_data1   = {16'hBEEF, 16'hCAFE};
        sel1       = 1'b0;
        exp1       = 16'h0000;
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        out_ready  = 1'b0;

        // 1: reset with input offered
        rst = 1'b1;
        offer0(3'd5, 8'h15);
        step();
        step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_sel", {29'd0, out_sel}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (4) begin
            step();
            chk("rst_no_emerge", {31'd0, out_valid}, 32'd0);
        end

        // 2: streaming, latency 2 cycles after first accept
        out_ready = 1'b1;
        for (int s = 0; s < 8; s++) begin
            offer0(3'(s), 8'h10 + 8'(s));
            step();
            chk("stream_latency", {31'd0, out_valid}, {31'd0, (s >= 2)});
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        drain0();

        // 3: backpressure fills three stages then stalls
        out_ready = 1'b0;
        #1;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            offer0(bp_sel[idx], bp_exp[idx]);
            acc = in_ready;
            step();
            if (acc) idx++;
        end
        chk("bp_accepted", idx, 32'd3);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (3) begin
            chk("bp_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h17});
            step();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_no_gap", {31'd0, out_valid}, 32'd1);
            if (idx < 5) begin
                offer0(bp_sel[idx], bp_exp[idx]);
                idx++;
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        in_valid = 1'b0;
        drain0();

        // 4: bubbles, then out_ready toggling
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b0;
            if (i == 0) offer0(3'd2, 8'h12);
            if (i == 2) offer0(3'd5, 8'h15);
            step();
            chk("bubble_valid", {31'd0, out_valid}, {31'd0, (i == 2 || i == 4)});
        end
        idx = 0;
        for (int c = 0; c < 20 && idx < 3; c++) begin
            out_ready = c[0];
            offer0(tg_sel[idx], tg_exp[idx]);
            #1;
            acc = in_ready;
            step();
            if (acc) idx++;
        end
        chk("toggle_accepted", idx, 32'd3);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain0();

        // 5: mid-operation reset discards in-flight items
        out_ready = 1'b0;
        for (int s = 1; s <= 3; s++) begin
            offer0(3'(s), 8'h10 + 8'(s));
            step();
        end
        rst = 1'b1;
        offer0(3'd4, 8'h14);
        step();
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            step();
            chk("mrst_stays_empty", {31'd0, out_valid}, 32'd0);
        end
        offer0(3'd6, 8'h16);
        step();
        in_valid = 1'b0;
        drain0();

        // 6: SEL_W=1, DATA_W=16 single-stage 2:1
        in_valid1 = 1'b1;
        sel1 = 1'b1;
        exp1 = 16'hBEEF;
        step();
        chk("w1_first", {15'd0, out_valid1, out_data1}, {15'd0, 1'b1, 16'hBEEF});
        sel1 = 1'b0;
        exp1 = 16'hCAFE;
        step();
        chk("w1_second", {15'd0, out_valid1, out_data1}, {15'd0, 1'b1, 16'hCAFE});
        in_valid1 = 1'b0;
        step();
        chk("w1_idle", {31'd0, out_valid1}, 32'd0);
        chk("w1_drained", q1.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
